// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : Single-port tile frame-buffer owner. Streams display reads
//            during active video and emits pipelined RGB with realigned syncs.
//            Round-robins the two writers onto the RAM port during blanking.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int FB_DEPTH = 19200,
    parameter int RD_LAT   = 1
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        req0,
    input  logic        req1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [11:0] data0,
    input  logic [11:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [11:0] ram_wdata,
    input  logic [11:0] ram_rdata,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [14:0] c_DEPTH       = 15'(FB_DEPTH);
    // Address register plus RAM latency; the colour register is the last stage.
    localparam int          c_SYNC_STAGES = RD_LAT + 1;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_ram_we;
    logic [14:0] r_ram_addr;
    logic [11:0] r_ram_wdata;
    logic        r_rr_req1;
    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic [2:0]  r_sync [c_SYNC_STAGES];

    logic [14:0] w_tile_row;
    logic [14:0] w_tile_col;
    logic [14:0] w_disp_addr;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_any;
    logic        w_pick1;
    logic [14:0] w_wr_addr;
    logic [11:0] w_wr_data;
    logic        w_unused;

    // row * 160 as shift-and-add, widened to 15 bits before shifting
    assign w_tile_row  = {7'd0, v_cnt[9:2]};
    assign w_tile_col  = {7'd0, h_cnt[9:2]};
    assign w_disp_addr = (w_tile_row << 7) + (w_tile_row << 5) + w_tile_col;
    assign w_unused    = ^{h_cnt[1:0], v_cnt[1:0]};

    // A requester still seeing its grant is ignored so one request is one write.
    always_comb begin
        w_elig0   = req0 & ~r_gnt0;
        w_elig1   = req1 & ~r_gnt1;
        w_any     = w_elig0 | w_elig1;
        w_pick1   = w_elig1 & (~w_elig0 | r_rr_req1);
        w_wr_addr = w_pick1 ? addr1 : addr0;
        w_wr_data = w_pick1 ? data1 : data0;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 15'd0;
            r_ram_wdata <= 12'd0;
            r_rr_req1   <= 1'b0;
        end else if (valid) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= w_disp_addr;
        end else if (w_any) begin
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_ram_we    <= (w_wr_addr < c_DEPTH);
            r_ram_addr  <= w_wr_addr;
            r_ram_wdata <= w_wr_data;
            r_rr_req1   <= ~w_pick1;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_ram_we <= 1'b0;
        end
    end

    // {valid, hsync, vsync} travel alongside the read so colour and syncs align.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b000;
            end
            r_rgb   <= 12'd0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_sync[0] <= {valid, hsync_in, vsync_in};
            for (int i = 1; i < c_SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_rgb   <= r_sync[c_SYNC_STAGES-1][2] ? ram_rdata : 12'd0;
            r_hsync <= r_sync[c_SYNC_STAGES-1][1];
            r_vsync <= r_sync[c_SYNC_STAGES-1][0];
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;

endmodule
`default_nettype wire
